// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: shared state type and constants for the per-frame sequencer.
package frame_seq_pkg;

  // Angle table size shared with the transformer / sincos ROMs.
  localparam int SINCOS_N_ANGLES = 256;

  // Minimum FEED residency: covers a late-rising feeder_busy and an empty list.
  localparam int FEED_MIN_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    BEGIN,
    CAM,
    FEED,
    DRAIN,
    DONE
  } frame_seq_state_t;

  // States in which a frame is in flight (frame_start there is an overrun).
  function automatic logic is_active(input frame_seq_state_t s);
    return (s == BEGIN) || (s == CAM) || (s == FEED) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/frame_sequencer_angle_stepper.sv
// angle_stepper: three rotation-index counters that advance once per accepted frame.
module angle_stepper
  import frame_seq_pkg::*;
#(
  parameter int N_ANGLES  = SINCOS_N_ANGLES,
  parameter int ANG_X_RST = 10,
  localparam int AW       = $clog2(N_ANGLES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic [2:0]    rot_en,
  output logic [AW-1:0] ang_x,
  output logic [AW-1:0] ang_y,
  output logic [AW-1:0] ang_z
);

  // Wraps at N_ANGLES so non-power-of-two tables also stay in range.
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == AW'(N_ANGLES - 1)) ? '0 : a + AW'(1);
  endfunction

  // Step each enabled axis on the accept strobe; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ang_x <= AW'(ANG_X_RST);
      ang_y <= '0;
      ang_z <= '0;
    end else if (step) begin
      if (rot_en[0]) ang_x <= wrap_inc(ang_x);
      if (rot_en[1]) ang_y <= wrap_inc(ang_y);
      if (rot_en[2]) ang_z <= wrap_inc(ang_z);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame begin/camera/feed/drain/swap controller (clk_render domain).
// Optional watchdog on FEED+DRAIN enabled by defining FRAME_SEQ_WATCHDOG_EN.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int N_ANGLES     = SINCOS_N_ANGLES,
  parameter int ANG_X_RST    = 10,
  parameter int FLUSH_CYCLES = 8,
  parameter int DROP_CNT_W   = 8,
`ifdef FRAME_SEQ_WATCHDOG_EN
  parameter int WDOG_CYCLES  = 2_000_000,
`endif
  localparam int AW          = $clog2(N_ANGLES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [2:0]            sw_rot_en,
  input  logic                  feeder_busy,
  input  logic                  renderer_busy,
  output logic                  render_begin,
  output logic                  cam_valid,
  output logic                  feeder_begin,
  output logic                  fb_swap,
  output logic [AW-1:0]         ang_x,
  output logic [AW-1:0]         ang_y,
  output logic [AW-1:0]         ang_z,
  output logic                  frame_active,
  output logic [15:0]           frame_cnt,
  output logic [DROP_CNT_W-1:0] drop_cnt
`ifdef FRAME_SEQ_WATCHDOG_EN
  ,
  output logic                  wdog_err
`endif
);

  localparam int FCW = $clog2(FEED_MIN_CYCLES + 1);
  localparam int FLW = $clog2(FLUSH_CYCLES + 1);

  frame_seq_state_t state, state_nxt;
  logic [FCW-1:0]   feed_cnt;
  logic [FLW-1:0]   flush_cnt;
  logic             accept;
  logic             swap_req;
  logic             cam_req;
  logic             feed_req;
  logic             drain_done;
  logic             overrun;
  logic             drain_idle;

  assign drain_idle = !renderer_busy && !feeder_busy;
  assign overrun    = frame_start && is_active(state);

  // Main state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Cycles spent in FEED, saturating at the minimum residency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  feed_cnt <= '0;
    else if (state != FEED)                      feed_cnt <= '0;
    else if (feed_cnt != FCW'(FEED_MIN_CYCLES))  feed_cnt <= feed_cnt + FCW'(1);
  end

  // Consecutive fully-idle cycles in DRAIN; any busy cycle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          flush_cnt <= '0;
    else if (state != DRAIN || !drain_idle) flush_cnt <= '0;
    else                                 flush_cnt <= flush_cnt + FLW'(1);
  end

`ifdef FRAME_SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wdog_cnt;
  logic           wdog_hit;

  assign wdog_hit = ((state == FEED) || (state == DRAIN)) &&
                    (wdog_cnt == WDW'(WDOG_CYCLES - 1));

  // Time spent waiting on feeder/renderer for the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                wdog_cnt <= '0;
    else if (state == FEED || state == DRAIN)  wdog_cnt <= wdog_cnt + WDW'(1);
    else                                       wdog_cnt <= '0;
  end

  // Sticky watchdog flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        wdog_err <= 1'b0;
    else if (wdog_hit) wdog_err <= 1'b1;
  end
`endif

  // Next-state and pulse-request decode.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    swap_req   = 1'b0;
    cam_req    = 1'b0;
    feed_req   = 1'b0;
    drain_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          accept    = 1'b1;
          state_nxt = BEGIN;
        end
      end
      BEGIN: begin
        cam_req   = 1'b1;
        state_nxt = CAM;
      end
      CAM: begin
        feed_req  = 1'b1;
        state_nxt = FEED;
      end
      FEED: begin
        if (feed_cnt >= FCW'(FEED_MIN_CYCLES - 1) && !feeder_busy) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_idle && flush_cnt == FLW'(FLUSH_CYCLES - 1)) begin
          drain_done = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        if (frame_start) begin
          accept    = 1'b1;
          swap_req  = 1'b1;
          state_nxt = BEGIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef FRAME_SEQ_WATCHDOG_EN
    if (wdog_hit) begin
      drain_done = 1'b0;
      state_nxt  = DONE;
    end
`endif
  end

  // Registered one-cycle pulses and the frame-in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      render_begin <= 1'b0;
      cam_valid    <= 1'b0;
      feeder_begin <= 1'b0;
      fb_swap      <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      render_begin <= accept;
      cam_valid    <= cam_req;
      feeder_begin <= feed_req;
      fb_swap      <= swap_req;
      frame_active <= is_active(state_nxt);
    end
  end

  // Completed-frame (wrapping) and dropped-frame (saturating) counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (drain_done) frame_cnt <= frame_cnt + 16'd1;
      if (overrun && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

  angle_stepper #(
    .N_ANGLES  (N_ANGLES),
    .ANG_X_RST (ANG_X_RST)
  ) u_angle_stepper (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (accept),
    .rot_en (sw_rot_en),
    .ang_x  (ang_x),
    .ang_y  (ang_y),
    .ang_z  (ang_z)
  );

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed bench with a pulse scoreboard for frame_sequencer.
module tb_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic [2:0] sw_rot_en = 3'b000;
  logic       feeder_busy = 1'b0;
  logic       renderer_busy = 1'b0;
  logic       render_begin, cam_valid, feeder_begin, fb_swap;
  logic [7:0] ang_x, ang_y, ang_z;
  logic       frame_active;
  logic [15:0] frame_cnt;
  logic [1:0] drop_cnt;
`ifdef FRAME_SEQ_WATCHDOG_EN
  logic       wdog_err;
`endif

  frame_sequencer #(
    .DROP_CNT_W (2)
`ifdef FRAME_SEQ_WATCHDOG_EN
    , .WDOG_CYCLES (1000)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .sw_rot_en     (sw_rot_en),
    .feeder_busy   (feeder_busy),
    .renderer_busy (renderer_busy),
    .render_begin  (render_begin),
    .cam_valid     (cam_valid),
    .feeder_begin  (feeder_begin),
    .fb_swap       (fb_swap),
    .ang_x         (ang_x),
    .ang_y         (ang_y),
    .ang_z         (ang_z),
    .frame_active  (frame_active),
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt)
`ifdef FRAME_SEQ_WATCHDOG_EN
    , .wdog_err    (wdog_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected pulse events: {fb_swap, feeder_begin, cam_valid, render_begin}.
  typedef struct {
    int         cyc;
    logic [3:0] pulses;
    logic [7:0] ax;
    logic [7:0] ay;
    logic [7:0] az;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   pass_cnt = 0;
  logic [7:0] m_ax = 8'd10;
  logic [7:0] m_ay = 8'd0;
  logic [7:0] m_az = 8'd0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Accepted frame_start at the current cycle; queues the three expected pulse cycles.
  task automatic applyStimulus(input logic [2:0] en, input logic swap, output int t);
    exp_t e;
    t = cyc;
    sw_rot_en = en;
    frame_start = 1'b1;
    if (en[0]) m_ax = m_ax + 8'd1;
    if (en[1]) m_ay = m_ay + 8'd1;
    if (en[2]) m_az = m_az + 8'd1;
    e.ax = m_ax; e.ay = m_ay; e.az = m_az;
    e.cyc = t + 1; e.pulses = swap ? 4'b1001 : 4'b0001; exp_q.push_back(e);
    e.cyc = t + 2; e.pulses = 4'b0010; exp_q.push_back(e);
    e.cyc = t + 3; e.pulses = 4'b0100; exp_q.push_back(e);
    tick(1);
    frame_start = 1'b0;
  endtask

  // frame_start that must be dropped: no pulses expected.
  task automatic applyOverrun();
    sw_rot_en = 3'b111;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  // Monitor: every pulse the DUT presents must match the head of the queue.
  logic [3:0] mon_p;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_p = {fb_swap, feeder_begin, cam_valid, render_begin};
      if (mon_p != 4'b0000) begin
        check_cnt++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL unexpected_pulse: got %b expected none (cycle %0d)", mon_p, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc == cyc && mon_e.pulses == mon_p && mon_e.ax == ang_x &&
              mon_e.ay == ang_y && mon_e.az == ang_z)
            pass_cnt++;
          else
            $display("[TB] FAIL pulse_event: got cyc %0d pulses %b ang %0d/%0d/%0d expected cyc %0d pulses %b ang %0d/%0d/%0d",
                     cyc, mon_p, ang_x, ang_y, ang_z, mon_e.cyc, mon_e.pulses,
                     mon_e.ax, mon_e.ay, mon_e.az);
        end
      end
    end
  end

  int t0, t1, t2, t3, t4, t5;
`ifdef FRAME_SEQ_WATCHDOG_EN
  int tw;
`endif

  initial begin
    tick(2);
    $display("[TB] reset values");
    checkOutput("rst_ang_x", 32'(ang_x), 32'd10);
    checkOutput("rst_ang_y", 32'(ang_y), 32'd0);
    checkOutput("rst_ang_z", 32'(ang_z), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("rst_frame_active", 32'(frame_active), 32'd0);
    checkOutput("rst_pulses", 32'({fb_swap, feeder_begin, cam_valid, render_begin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Frame 1: long feeder/renderer activity and two overruns during FEED.
    $display("[TB] frame 1: busy feeder/renderer, overruns in FEED");
    applyStimulus(3'b001, 1'b0, t0);
    waitUntil(t0 + 3);
    feeder_busy = 1'b1;
    renderer_busy = 1'b1;
    waitUntil(t0 + 50);
    applyOverrun();
    waitUntil(t0 + 52);
    applyOverrun();
    waitUntil(t0 + 55);
    checkOutput("f1_drop_cnt", 32'(drop_cnt), 32'd2);
    checkOutput("f1_ang_x_held", 32'(ang_x), 32'd11);
    checkOutput("f1_active", 32'(frame_active), 32'd1);
    waitUntil(t0 + 103);
    feeder_busy = 1'b0;
    waitUntil(t0 + 153);
    renderer_busy = 1'b0;
    waitUntil(t0 + 160);
    checkOutput("f1_active_before_done", 32'(frame_active), 32'd1);
    checkOutput("f1_frame_cnt_before_done", 32'(frame_cnt), 32'd0);
    waitUntil(t0 + 161);
    checkOutput("f1_active_at_done", 32'(frame_active), 32'd0);
    checkOutput("f1_frame_cnt_at_done", 32'(frame_cnt), 32'd1);

    // Frame 2: swap with begin, renderer glitch at flush count 5.
    $display("[TB] frame 2: swap, flush restart");
    waitUntil(t0 + 165);
    applyStimulus(3'b110, 1'b1, t1);
    waitUntil(t1 + 10);
    renderer_busy = 1'b1;
    tick(1);
    renderer_busy = 1'b0;
    waitUntil(t1 + 18);
    checkOutput("f2_active_before_done", 32'(frame_active), 32'd1);
    waitUntil(t1 + 19);
    checkOutput("f2_active_at_done", 32'(frame_active), 32'd0);
    checkOutput("f2_frame_cnt", 32'(frame_cnt), 32'd2);

    // Frame 3: empty triangle list; frame_start on the DRAIN completion cycle.
    $display("[TB] frame 3: empty list, overrun at drain end");
    waitUntil(t1 + 22);
    applyStimulus(3'b111, 1'b1, t2);
    waitUntil(t2 + 12);
    checkOutput("f3_active_last_drain", 32'(frame_active), 32'd1);
    applyOverrun();
    checkOutput("f3_active_at_done", 32'(frame_active), 32'd0);
    checkOutput("f3_frame_cnt", 32'(frame_cnt), 32'd3);
    checkOutput("f3_drop_cnt", 32'(drop_cnt), 32'd3);

    // Frame 4: two more overruns, drop counter saturates.
    $display("[TB] frame 4: drop counter saturation");
    waitUntil(t2 + 16);
    applyStimulus(3'b000, 1'b1, t3);
    applyOverrun();
    waitUntil(t3 + 4);
    applyOverrun();
    waitUntil(t3 + 6);
    checkOutput("f4_drop_sat", 32'(drop_cnt), 32'd3);
    checkOutput("f4_ang_y_held", 32'(ang_y), 32'd2);
    waitUntil(t3 + 13);
    checkOutput("f4_frame_cnt", 32'(frame_cnt), 32'd4);

`ifdef FRAME_SEQ_WATCHDOG_EN
    $display("[TB] watchdog: renderer stuck busy");
    waitUntil(t3 + 16);
    applyStimulus(3'b000, 1'b1, tw);
    waitUntil(tw + 3);
    renderer_busy = 1'b1;
    waitUntil(tw + 1002);
    checkOutput("wd_active_before", 32'(frame_active), 32'd1);
    checkOutput("wd_err_before", 32'(wdog_err), 32'd0);
    waitUntil(tw + 1003);
    checkOutput("wd_active_at", 32'(frame_active), 32'd0);
    checkOutput("wd_err_at", 32'(wdog_err), 32'd1);
    checkOutput("wd_frame_cnt", 32'(frame_cnt), 32'd4);
    renderer_busy = 1'b0;
    waitUntil(tw + 1006);
`else
    waitUntil(t3 + 16);
`endif

    // Frame 5: async reset in the middle of DRAIN.
    $display("[TB] frame 5: reset mid-drain");
    applyStimulus(3'b001, 1'b1, t4);
    waitUntil(t4 + 3);
    renderer_busy = 1'b1;
    waitUntil(t4 + 10);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_ang_x", 32'(ang_x), 32'd10);
    checkOutput("mr_ang_y", 32'(ang_y), 32'd0);
    checkOutput("mr_ang_z", 32'(ang_z), 32'd0);
    checkOutput("mr_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("mr_drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("mr_active", 32'(frame_active), 32'd0);
    m_ax = 8'd10;
    m_ay = 8'd0;
    m_az = 8'd0;
    renderer_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Frame 6: first frame after reset must not swap.
    $display("[TB] frame 6: first frame after reset");
    applyStimulus(3'b001, 1'b0, t5);
    waitUntil(t5 + 13);
    checkOutput("f6_frame_cnt", 32'(frame_cnt), 32'd1);
    checkOutput("f6_active", 32'(frame_active), 32'd0);
    tick(4);

    while (exp_q.size() > 0) begin
      check_cnt++;
      $display("[TB] FAIL missing_pulse: got none expected %b at cycle %0d",
               exp_q[0].pulses, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Per-frame controller in the clk_render domain. It replaces the ad-hoc begin/camera/feeder/swap glue around render_manager, triangle_feeder and double_framebuffer.
- On each accepted frame start it runs a fixed sequence: renderer begin, camera-transform pulse, feeder kick, then drain. It issues the framebuffer swap only at a frame boundary after a completed frame.
- It owns the rotation-angle counters and counts overrun (dropped) frames.

Parameters:
- N_ANGLES, 256, angle table size; angle width AW = $clog2(N_ANGLES).
- ANG_X_RST, 10, reset value of ang_x (ang_y, ang_z reset to 0).
- FLUSH_CYCLES, 8, consecutive idle cycles required after renderer_busy falls (depthbuffer pipeline drain).
- DROP_CNT_W, 8, width of the dropped-frame counter.
- WDOG_CYCLES, 2_000_000, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  render clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse, already synchronized into clk domain.
- sw_rot_en  in  3  per-axis rotate enable {z,y,x}, already synchronized.
- feeder_busy  in  1  triangle_feeder busy.
- renderer_busy  in  1  render_manager busy.
- render_begin  out  1  one-cycle begin_frame to render_manager.
- cam_valid  out  1  one-cycle camera_transform_valid.
- feeder_begin  out  1  one-cycle begin_frame to triangle_feeder.
- fb_swap  out  1  one-cycle swap to double_framebuffer.
- ang_x, ang_y, ang_z  out  AW  rotation indices to the sincos feeders.
- frame_active  out  1  high from accept to DONE.
- frame_cnt  out  16  completed frames, wraps.
- drop_cnt  out  DROP_CNT_W  overrun frames, saturating.
- wdog_err  out  1  sticky watchdog flag; present only with FRAME_SEQ_WATCHDOG_EN.

Behaviour:
- Reset (async, rst_n low): state IDLE, all pulse outputs 0, frame_active 0, frame_cnt 0, drop_cnt 0, wdog_err 0, ang_x=ANG_X_RST, ang_y=ang_z=0. All outputs are registered.
- States and transitions:
  - IDLE: on frame_start at cycle T -> BEGIN. No swap, since there is no completed frame after reset.
  - BEGIN (T+1): render_begin=1; angles step: each axis with sw_rot_en bit set increments mod N_ANGLES. -> CAM.
  - CAM (T+2): cam_valid=1. The sincos outputs for the new angles are valid by this cycle (1-cycle ROM latency). -> FEED.
  - FEED (T+3): feeder_begin=1 on the entry cycle only. Leave once at least 2 cycles have elapsed in FEED and feeder_busy=0 -> DRAIN. The 2-cycle minimum covers feeder_busy rising late and an empty triangle list.
  - DRAIN: wait for renderer_busy=0 and feeder_busy=0 for FLUSH_CYCLES consecutive cycles. Any busy cycle restarts the count. Then -> DONE, frame_cnt+1.
  - DONE: on frame_start at cycle T: fb_swap=1 and render_begin=1 both at T+1, then proceed as BEGIN, so swap and begin coincide.
- frame_active is high in BEGIN, CAM, FEED and DRAIN.
- Overrun: frame_start in BEGIN, CAM, FEED or DRAIN is ignored for sequencing; no swap; drop_cnt+1, saturating at all-ones.
- Simultaneous events:
  - frame_start in the same cycle DRAIN completes: treat as an overrun. drop_cnt+1, enter DONE, wait for the next frame_start.
- Angles only change on accepted frames, never on dropped ones.
- Outputs pulse for exactly one cycle, with no back-to-back repeats.
- Reset mid-frame: immediate return to IDLE. Pulses already issued are not retracted. Downstream blocks share the reset.

Optional Feature:
- Macro: FRAME_SEQ_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in FEED+DRAIN.
  - Reaching WDOG_CYCLES forces DONE, sets wdog_err (cleared only by reset) and does not increment frame_cnt.
  - The next swap still occurs.
- Undefined: no counter; wdog_err port absent; FEED/DRAIN wait indefinitely.

Decomposition:
- Package frame_seq_pkg: state enum frame_seq_state_t (IDLE, BEGIN, CAM, FEED, DRAIN, DONE) and localparam FEED_MIN_CYCLES=2.
- N_ANGLES default comes from the existing transformer/sincos constants.
- One natural sub-module: angle_stepper. It holds three AW-bit counters with per-axis enable and a step strobe, instantiated once.

Test Plan:
- Reset, then frame_start at T -> render_begin@T+1, cam_valid@T+2, feeder_begin@T+3, fb_swap never; ang_x=10→11 only if sw_rot_en[0]=1.
- Feeder busy 100 cycles, renderer busy until 150, FLUSH_CYCLES=8 -> DONE 8 cycles after renderer_busy falls; frame_cnt=1; next frame_start -> fb_swap and render_begin together at +1.
- Two frame_starts during FEED -> drop_cnt=2, no swap, angles unchanged. With DROP_CNT_W=2 and 5 overruns -> drop_cnt=3.
- renderer_busy glitch high for 1 cycle at flush count 5 -> count restarts; DONE delayed by 6 cycles.
- feeder_busy never asserted (empty list) -> FEED exits after 2 cycles; frame completes after flush.
- With FRAME_SEQ_WATCHDOG_EN, WDOG_CYCLES=1000, renderer_busy stuck 1 -> DONE at 1000 cycles, wdog_err=1, frame_cnt unchanged; async rst_n mid-DRAIN -> IDLE, all outputs at reset values same cycle.
